// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point constants for the mandelbrot pipeline.
// Coordinates are two's complement Q3.(BITWIDTH-3).
package mandelbrot_pkg;

  localparam int BITWIDTH  = 11;
  localparam int FRAC_BITS = BITWIDTH - 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [BITWIDTH-1:0] ONE =
    BITWIDTH'(1) << FRAC_BITS;
  localparam logic [BITWIDTH-1:0] MIN =
    {1'b1, {(BITWIDTH-1){1'b0}}};

endpackage

// File: rtl/mandelbrot_axis_stepper.sv
// One scan axis: index counter plus fixed-point coordinate that
// steps by a signed pitch; load/wrap restart it at an origin.
module mandelbrot_axis_stepper #(
  parameter int IDX_W = 8,
  parameter int BW    = 11,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_advance,
  input  logic             i_wrap,
  input  logic [BW-1:0]    i_load_val,
  input  logic [BW-1:0]    i_origin,
  input  logic [BW-1:0]    i_step,
  output logic [IDX_W-1:0] o_idx,
  output logic [BW-1:0]    o_coord
);

  logic [IDX_W-1:0] r_idx;
  logic [BW-1:0]    r_coord;
  logic [BW-1:0]    w_next;

  // modulo 2^BW arithmetic, wrap is intentional
  assign w_next = DOWN ? (r_coord - i_step)
                       : (r_coord + i_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_coord <= '0;
    end else if (i_load) begin
      r_idx   <= '0;
      r_coord <= i_load_val;
    end else if (i_wrap) begin
      r_idx   <= '0;
      r_coord <= i_origin;
    end else if (i_advance) begin
      r_idx   <= r_idx + IDX_W'(1);
      r_coord <= w_next;
    end
  end

  assign o_idx   = r_idx;
  assign o_coord = r_coord;

endmodule

// File: rtl/mandelbrot_coord_gen.sv
// Raster-order viewport scanner feeding c = (re, im) to the
// mandelbrot iteration core over a valid/ready handshake.
module mandelbrot_coord_gen #(
  parameter int BITWIDTH = mandelbrot_pkg::BITWIDTH,
  parameter int COLS_W   = 8,
  parameter int ROWS_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [BITWIDTH-1:0] cfg_re0,
  input  logic [BITWIDTH-1:0] cfg_im0,
  input  logic [BITWIDTH-1:0] cfg_step,
  input  logic [COLS_W-1:0]   cfg_cols,
  input  logic [ROWS_W-1:0]   cfg_rows,
  output logic [BITWIDTH-1:0] c_re,
  output logic [BITWIDTH-1:0] c_im,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [COLS_W-1:0]   col,
  output logic [ROWS_W-1:0]   row,
  output logic                end_of_row,
  output logic                end_of_frame,
  output logic                busy,
  output logic                frame_done
);
  import mandelbrot_pkg::*;

  state_t              r_state;
  logic [BITWIDTH-1:0] r_re0_l;
  logic [BITWIDTH-1:0] r_im0_l;
  logic [BITWIDTH-1:0] r_step_l;
  logic [COLS_W-1:0]   r_cols_l;
  logic [ROWS_W-1:0]   r_rows_l;
  logic                r_frame_done;

  logic w_emit;
  logic w_go;
  logic w_xfer;
  logic w_last_col;
  logic w_last_row;
  logic w_x_adv;
  logic w_x_wrap;
  logic w_done;

  assign w_emit     = (r_state == EMIT);
  assign w_go       = (r_state == IDLE) && start && !stop;
  assign w_xfer     = w_emit && c_ready;
  assign w_last_col = (col == r_cols_l);
  assign w_last_row = (row == r_rows_l);
  assign w_x_adv    = w_xfer && !w_last_col;
  assign w_x_wrap   = w_xfer && w_last_col && !w_last_row;
  assign w_done     = w_xfer && w_last_col && w_last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_re0_l      <= '0;
      r_im0_l      <= '0;
      r_step_l     <= '0;
      r_cols_l     <= '0;
      r_rows_l     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done && !stop;
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state  <= EMIT;
            r_re0_l  <= cfg_re0;
            r_im0_l  <= cfg_im0;
            r_step_l <= cfg_step;
            r_cols_l <= cfg_cols;
            r_rows_l <= cfg_rows;
          end
        end
        EMIT: begin
          if (stop || w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mandelbrot_axis_stepper #(
    .IDX_W (COLS_W),
    .BW    (BITWIDTH),
    .DOWN  (1'b0)
  ) u_re (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_go),
    .i_advance  (w_x_adv),
    .i_wrap     (w_x_wrap),
    .i_load_val (cfg_re0),
    .i_origin   (r_re0_l),
    .i_step     (r_step_l),
    .o_idx      (col),
    .o_coord    (c_re)
  );

  // imaginary axis descends; it never wraps within a frame
  mandelbrot_axis_stepper #(
    .IDX_W (ROWS_W),
    .BW    (BITWIDTH),
    .DOWN  (1'b1)
  ) u_im (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_go),
    .i_advance  (w_x_wrap),
    .i_wrap     (1'b0),
    .i_load_val (cfg_im0),
    .i_origin   (r_im0_l),
    .i_step     (r_step_l),
    .o_idx      (row),
    .o_coord    (c_im)
  );

  assign c_valid      = w_emit;
  assign busy         = w_emit;
  assign end_of_row   = w_emit && w_last_col;
  assign end_of_frame = w_emit && w_last_col && w_last_row;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Scoreboard bench for mandelbrot_coord_gen: expected pixels are
// queued at start and compared on every accepted transfer.
module tb_mandelbrot_coord_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [10:0] cfg_re0;
  logic [10:0] cfg_im0;
  logic [10:0] cfg_step;
  logic [7:0]  cfg_cols;
  logic [7:0]  cfg_rows;
  logic [10:0] c_re;
  logic [10:0] c_im;
  logic        c_valid;
  logic        c_ready;
  logic [7:0]  col;
  logic [7:0]  row;
  logic        end_of_row;
  logic        end_of_frame;
  logic        busy;
  logic        frame_done;

  typedef struct {
    logic [10:0] re;
    logic [10:0] im;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        eor;
    logic        eof;
  } pix_t;

  pix_t q[$];
  pix_t p;
  int   n_checks;
  int   n_errors;

  mandelbrot_coord_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_re0      (cfg_re0),
    .cfg_im0      (cfg_im0),
    .cfg_step     (cfg_step),
    .cfg_cols     (cfg_cols),
    .cfg_rows     (cfg_rows),
    .c_re         (c_re),
    .c_im         (c_im),
    .c_valid      (c_valid),
    .c_ready      (c_ready),
    .col          (col),
    .row          (row),
    .end_of_row   (end_of_row),
    .end_of_frame (end_of_frame),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // independent raster model, coordinates wrap mod 2^11
  task automatic push_frame(input logic [10:0] re0,
                            input logic [10:0] im0,
                            input logic [10:0] step,
                            input int cols,
                            input int rows,
                            input int max_pix);
    int n;
    n = 0;
    for (int r = 0; r <= rows; r++) begin
      for (int c = 0; c <= cols; c++) begin
        pix_t e;
        int   tre;
        int   tim;
        tre = int'(re0) + c * int'(step);
        tim = int'(im0) - r * int'(step);
        e.re  = tre[10:0];
        e.im  = tim[10:0];
        e.col = 8'(c);
        e.row = 8'(r);
        e.eor = (c == cols);
        e.eof = (c == cols) && (r == rows);
        if (n < max_pix) q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic start_frame(input logic [10:0] re0,
                             input logic [10:0] im0,
                             input logic [10:0] step,
                             input int cols,
                             input int rows,
                             input int max_pix);
    cfg_re0  = re0;
    cfg_im0  = im0;
    cfg_step = step;
    cfg_cols = 8'(cols);
    cfg_rows = 8'(rows);
    push_frame(re0, im0, step, cols, rows, max_pix);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain_and_check_done(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() != 0) begin
      check({tag, "_drain_timeout"}, 32'(q.size()), 32'(0));
      q.delete();
    end
    check({tag, "_frame_done"}, 32'(frame_done), 32'(1));
    check({tag, "_valid_off"}, 32'(c_valid), 32'(0));
    check({tag, "_busy_off"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(frame_done), 32'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && c_valid && c_ready) begin
      if (q.size() == 0) begin
        check("unexpected_xfer", 32'(1), 32'(0));
      end else begin
        p = q.pop_front();
        check("c_re", 32'(c_re), 32'(p.re));
        check("c_im", 32'(c_im), 32'(p.im));
        check("col", 32'(col), 32'(p.col));
        check("row", 32'(row), 32'(p.row));
        check("eor", 32'(end_of_row), 32'(p.eor));
        check("eof", 32'(end_of_frame), 32'(p.eof));
        check("busy_emit", 32'(busy), 32'(1));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    c_ready  = 1'b0;
    cfg_re0  = '0;
    cfg_im0  = '0;
    cfg_step = '0;
    cfg_cols = '0;
    cfg_rows = '0;
    #1;
    check("rst_valid", 32'(c_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    check("rst_re", 32'(c_re), 32'(0));
    check("rst_im", 32'(c_im), 32'(0));
    check("rst_col", 32'(col), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic 3x2 frame
    c_ready = 1'b1;
    start_frame(11'h600, 11'h100, 11'h040, 2, 1, 99);
    check("s1_latency_valid", 32'(c_valid), 32'(1));
    drain_and_check_done("s1");

    // 2: backpressure on the second pixel
    start_frame(11'h600, 11'h100, 11'h040, 2, 1, 99);
    @(posedge clk); #1;
    c_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s2_hold_re", 32'(c_re), 32'(11'h640));
      check("s2_hold_col", 32'(col), 32'(1));
      check("s2_hold_valid", 32'(c_valid), 32'(1));
    end
    @(posedge clk); #1;
    c_ready = 1'b1;
    drain_and_check_done("s2");

    // 3: real axis wraps from +3.75 to -4.0
    start_frame(11'h3C0, 11'h000, 11'h040, 2, 0, 99);
    drain_and_check_done("s3");

    // 4: stop coincident with the second transfer
    start_frame(11'h600, 11'h100, 11'h040, 2, 1, 2);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("s4_left", 32'(q.size()), 32'(0));
    check("s4_valid", 32'(c_valid), 32'(0));
    check("s4_busy", 32'(busy), 32'(0));
    check("s4_no_done", 32'(frame_done), 32'(0));
    @(posedge clk); #1;
    check("s4_no_done2", 32'(frame_done), 32'(0));
    start_frame(11'h600, 11'h100, 11'h040, 2, 1, 99);
    drain_and_check_done("s4r");

    // 5: async reset mid-frame under backpressure
    c_ready = 1'b0;
    start_frame(11'h600, 11'h100, 11'h040, 2, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("s5_valid", 32'(c_valid), 32'(0));
    check("s5_busy", 32'(busy), 32'(0));
    check("s5_re", 32'(c_re), 32'(0));
    check("s5_im", 32'(c_im), 32'(0));
    check("s5_col", 32'(col), 32'(0));
    check("s5_eor", 32'(end_of_row), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s5_idle", 32'(busy), 32'(0));
    c_ready = 1'b1;
    start_frame(11'h600, 11'h100, 11'h040, 2, 0, 99);
    cfg_re0  = 11'h123;
    cfg_step = 11'h001;
    cfg_cols = 8'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain_and_check_done("s5");
    check("s5_no_restart", 32'(busy), 32'(0));

    // 6: single-pixel frame
    start_frame(11'h7F0, 11'h010, 11'h040, 0, 0, 99);
    drain_and_check_done("s6");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
